// File: rtl/timer_seq_fsm_pkg.sv
`default_nettype none
// ============================================================================
// Module  : timer_seq_pkg
// Brief   : Shared state encoding and counter-width helpers for timer_seq_fsm.
// Revision: 1.0 - initial release
// ============================================================================
package timer_seq_pkg;

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_COUNT  = 2'd2,
        ST_WAIT   = 2'd3
    } state_t;

    // Bits needed to hold 0..n-1, never less than one.
    function automatic int tick_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int delay_w(input int n);
        return (n > 1) ? n : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/timer_seq_fsm_if.sv
`default_nettype none
// ============================================================================
// Module  : timer_seq_fsm_if
// Brief   : Serial input, control and status bundle of timer_seq_fsm.
// Revision: 1.0 - initial release
// ============================================================================
interface timer_seq_fsm_if #(
    parameter int DELAY_W = 4
) ();
    logic               x;
    logic               abort;
    logic               ack;
    logic               shift_ena;
    logic               counting;
    logic               done;
    logic [DELAY_W-1:0] delay_val;
    logic [DELAY_W-1:0] remaining;

    modport master (
        output x, abort, ack,
        input  shift_ena, counting, done, delay_val, remaining
    );

    modport slave (
        input  x, abort, ack,
        output shift_ena, counting, done, delay_val, remaining
    );
endinterface
`default_nettype wire

// File: rtl/timer_seq_fsm_pattern_det.sv
`default_nettype none
// ============================================================================
// Module  : pattern_det
// Brief   : Overlapping serial start-pattern detector with fill tracking.
// Revision: 1.0 - initial release
// ============================================================================
module pattern_det
    import timer_seq_pkg::*;
#(
    parameter int                 PAT_LEN = 4,
    parameter logic [PAT_LEN-1:0] PATTERN = 4'b1101
) (
    input  wire logic clk,
    input  wire logic reset_n,
    input  wire logic en,
    input  wire logic clr,
    input  wire logic x,
    output logic      match
);

    localparam int                c_fill_w    = tick_w(PAT_LEN);
    localparam logic [c_fill_w-1:0] c_fill_need = c_fill_w'(PAT_LEN - 1);

    // The oldest history bit falls out of every comparison window, so only
    // the newest PAT_LEN-1 bits need storage.
    logic [PAT_LEN-2:0]  r_hist;
    logic [c_fill_w-1:0] r_fill;
    logic [PAT_LEN-1:0]  w_window;

    assign w_window = {r_hist, x};
    assign match    = en && (r_fill == c_fill_need) && (w_window == PATTERN);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_hist <= '0;
            r_fill <= '0;
        end else if (clr) begin
            r_hist <= '0;
            r_fill <= '0;
        end else if (en) begin
            r_hist <= w_window[PAT_LEN-2:0];
            if (r_fill != c_fill_need) begin
                r_fill <= r_fill + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/timer_seq_fsm.sv
`default_nettype none
// ============================================================================
// Module  : timer_seq_fsm
// Brief   : Pattern-triggered delay timer: search, shift delay, count, wait ack.
// Revision: 1.0 - initial release
// ============================================================================
module timer_seq_fsm
    import timer_seq_pkg::*;
#(
    parameter int                 PAT_LEN = 4,
    parameter logic [PAT_LEN-1:0] PATTERN = 4'b1101,
    parameter int                 DELAY_W = 4,
    parameter int                 TICK    = 1000
) (
    input  wire logic        clk,
    input  wire logic        reset_n,
    timer_seq_fsm_if.slave   bus
);

    localparam int                   c_tick_w     = tick_w(TICK);
    localparam int                   c_dly_w      = delay_w(DELAY_W);
    localparam int                   c_shift_w    = tick_w(DELAY_W);
    localparam logic [c_tick_w-1:0]  c_tick_max   = c_tick_w'(TICK - 1);
    localparam logic [c_shift_w-1:0] c_shift_last = c_shift_w'(DELAY_W - 1);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_shift_w-1:0] r_shift_cnt;
    logic [c_dly_w-1:0]   r_delay;
    logic [c_tick_w-1:0]  r_tick;
    logic [c_dly_w-1:0]   r_remaining;
    logic [c_dly_w:0]     w_delay_shift;
    logic                 w_match;
    logic                 w_det_en;
    logic                 w_det_clr;
    logic                 w_shift_last;
    logic                 w_tick_zero;
    logic                 w_rem_zero;

    // History is wiped whenever the search is left, so every new search
    // starts from an empty fill count.
    assign w_det_en  = (r_state == ST_SEARCH);
    assign w_det_clr = (r_state != ST_SEARCH) || bus.abort;

    pattern_det #(
        .PAT_LEN (PAT_LEN),
        .PATTERN (PATTERN)
    ) u_pattern_det (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (w_det_en),
        .clr     (w_det_clr),
        .x       (bus.x),
        .match   (w_match)
    );

    assign w_delay_shift = {r_delay, bus.x};
    assign w_shift_last  = (r_shift_cnt == c_shift_last);
    assign w_tick_zero   = (r_tick == '0);
    assign w_rem_zero    = (r_remaining == '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_SEARCH;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (bus.abort) begin
            w_state_nxt = ST_SEARCH;
        end else begin
            case (r_state)
                ST_SEARCH: if (w_match)                   w_state_nxt = ST_SHIFT;
                ST_SHIFT:  if (w_shift_last)              w_state_nxt = ST_COUNT;
                ST_COUNT:  if (w_tick_zero && w_rem_zero) w_state_nxt = ST_WAIT;
                ST_WAIT:   if (bus.ack)                   w_state_nxt = ST_SEARCH;
                default:                                  w_state_nxt = ST_SEARCH;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_shift_cnt <= '0;
            r_delay     <= '0;
            r_tick      <= '0;
            r_remaining <= '0;
        end else if (bus.abort) begin
            r_shift_cnt <= '0;
            r_tick      <= '0;
            r_remaining <= '0;
        end else begin
            case (r_state)
                ST_SHIFT: begin
                    r_delay <= w_delay_shift[c_dly_w-1:0];
                    if (w_shift_last) begin
                        r_shift_cnt <= '0;
                        r_tick      <= c_tick_max;
                        r_remaining <= w_delay_shift[c_dly_w-1:0];
                    end else begin
                        r_shift_cnt <= r_shift_cnt + 1'b1;
                    end
                end
                ST_COUNT: begin
                    // Each delay unit spans TICK clocks, including unit zero.
                    if (!w_tick_zero) begin
                        r_tick <= r_tick - 1'b1;
                    end else if (!w_rem_zero) begin
                        r_remaining <= r_remaining - 1'b1;
                        r_tick      <= c_tick_max;
                    end
                end
                default: begin
                    r_shift_cnt <= '0;
                end
            endcase
        end
    end

    assign bus.shift_ena = (r_state == ST_SHIFT);
    assign bus.counting  = (r_state == ST_COUNT);
    assign bus.done      = (r_state == ST_WAIT);
    assign bus.delay_val = r_delay;
    assign bus.remaining = r_remaining;

endmodule
`default_nettype wire

// File: tb/tb_timer_seq_fsm.sv
`default_nettype none
// ============================================================================
// Module  : tb_timer_seq_fsm
// Brief   : Directed and random bench for timer_seq_fsm against a phase model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_timer_seq_fsm;

    localparam int         c_pat_len = 4;
    localparam logic [3:0] c_pattern = 4'b1101;
    localparam int         c_delay_w = 4;
    localparam int         c_tick    = 4;

    localparam int c_ph_search = 0;
    localparam int c_ph_shift  = 1;
    localparam int c_ph_count  = 2;
    localparam int c_ph_wait   = 3;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    timer_seq_fsm_if #(.DELAY_W(c_delay_w)) bus ();

    timer_seq_fsm #(
        .PAT_LEN (c_pat_len),
        .PATTERN (c_pattern),
        .DELAY_W (c_delay_w),
        .TICK    (c_tick)
    ) u_dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int n_cmp = 0;
    int n_err = 0;
    int obs_sh, obs_cnt, obs_done;

    // Reference model: phase plus plain integer bookkeeping.
    int m_phase;
    bit m_hist[$];
    int m_nbits, m_dv, m_delay, m_elapsed;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = c_ph_search;
        m_hist.delete();
        m_nbits = 0; m_dv = 0; m_delay = 0; m_elapsed = 0;
    endtask

    function automatic bit hist_is_pattern();
        logic [3:0] pat;
        pat = c_pattern;
        for (int i = 0; i < c_pat_len; i++)
            if (m_hist[i] != pat[c_pat_len-1-i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_step(input bit xi, input bit ai, input bit ki);
        case (m_phase)
            c_ph_search: begin
                if (ai) m_hist.delete();
                else begin
                    m_hist.push_back(xi);
                    if (m_hist.size() > c_pat_len) void'(m_hist.pop_front());
                    if (m_hist.size() == c_pat_len && hist_is_pattern()) begin
                        m_phase = c_ph_shift;
                        m_nbits = 0;
                        m_hist.delete();
                    end
                end
            end
            c_ph_shift: begin
                if (ai) m_phase = c_ph_search;
                else begin
                    m_dv = ((m_dv << 1) | int'(xi)) & ((1 << c_delay_w) - 1);
                    m_nbits++;
                    if (m_nbits == c_delay_w) begin
                        m_delay   = m_dv;
                        m_elapsed = 0;
                        m_phase   = c_ph_count;
                    end
                end
            end
            c_ph_count: begin
                if (ai) m_phase = c_ph_search;
                else begin
                    m_elapsed++;
                    if (m_elapsed == (m_delay + 1) * c_tick) m_phase = c_ph_wait;
                end
            end
            default: if (ai || ki) m_phase = c_ph_search;
        endcase
    endtask

    task automatic check_outputs();
        int exp_rem;
        exp_rem = (m_phase == c_ph_count) ? (m_delay - m_elapsed / c_tick) : 0;
        check_val("shift_ena", bus.shift_ena, m_phase == c_ph_shift);
        check_val("counting",  bus.counting,  m_phase == c_ph_count);
        check_val("done",      bus.done,      m_phase == c_ph_wait);
        check_val("delay_val", bus.delay_val, m_dv);
        check_val("remaining", bus.remaining, exp_rem);
        obs_sh   += int'(bus.shift_ena);
        obs_cnt  += int'(bus.counting);
        obs_done += int'(bus.done);
    endtask

    task automatic run_cycle(input bit xi, input bit ai, input bit ki);
        @(negedge clk);
        check_outputs();
        bus.x = xi; bus.abort = ai; bus.ack = ki;
        model_step(xi, ai, ki);
    endtask

    task automatic feed_bits(input logic [15:0] bits, input int n, input bit ki);
        for (int i = n - 1; i >= 0; i--) run_cycle(bits[i], 1'b0, ki);
    endtask

    task automatic idle(input int n, input bit ki);
        for (int i = 0; i < n; i++) run_cycle(1'b0, 1'b0, ki);
    endtask

    task automatic clear_obs();
        obs_sh = 0; obs_cnt = 0; obs_done = 0;
    endtask

    initial begin
        bus.x = 1'b0; bus.abort = 1'b0; bus.ack = 1'b0;
        model_reset();
        clear_obs();
        repeat (2) @(negedge clk);
        check_outputs();
        reset_n = 1'b1;
        model_step(1'b0, 1'b0, 1'b0);

        // Basic sequence, delay 5.
        clear_obs();
        feed_bits(16'b1101_0101, 8, 1'b0);
        idle(30, 1'b0);
        check_val("shift_cycles_d5", obs_sh, 4);
        check_val("count_cycles_d5", obs_cnt, 24);
        check_val("done_cycles_d5", obs_done, 6);
        check_val("delay_val_d5", bus.delay_val, 5);
        run_cycle(1'b0, 1'b0, 1'b1);
        idle(2, 1'b0);

        // Overlapping pattern, delay 0.
        clear_obs();
        feed_bits(16'b1_1101_0000, 9, 1'b0);
        idle(8, 1'b0);
        check_val("count_cycles_overlap", obs_cnt, 4);
        run_cycle(1'b0, 1'b0, 1'b1);

        // Maximum delay.
        clear_obs();
        feed_bits(16'b1101_1111, 8, 1'b0);
        idle(70, 1'b0);
        check_val("count_cycles_d15", obs_cnt, 64);
        run_cycle(1'b0, 1'b0, 1'b1);

        // Abort in the 10th COUNT cycle, then restart.
        clear_obs();
        feed_bits(16'b1101_0101, 8, 1'b0);
        idle(9, 1'b0);
        run_cycle(1'b0, 1'b1, 1'b0);
        run_cycle(1'b0, 1'b0, 1'b0);
        check_val("count_cycles_abort", obs_cnt, 10);
        check_val("remaining_abort", bus.remaining, 0);
        clear_obs();
        feed_bits(16'b1101_0000, 8, 1'b0);
        idle(6, 1'b0);
        check_val("count_cycles_restart", obs_cnt, 4);
        run_cycle(1'b0, 1'b0, 1'b1);

        // ack held through the whole sequence.
        clear_obs();
        feed_bits(16'b1101_0001, 8, 1'b1);
        idle(20, 1'b1);
        check_val("done_cycles_ack_held", obs_done, 1);
        check_val("count_cycles_ack_held", obs_cnt, 8);

        // ack pulses during COUNT are ignored.
        clear_obs();
        feed_bits(16'b1101_0010, 8, 1'b0);
        for (int i = 0; i < 12; i++) run_cycle(1'b0, 1'b0, bit'(i % 2));
        idle(3, 1'b0);
        check_val("count_cycles_ack_pulse", obs_cnt, 12);
        check_val("done_cycles_ack_pulse", obs_done, 3);
        run_cycle(1'b0, 1'b0, 1'b1);

        // Asynchronous reset pulse between edges while waiting for ack.
        feed_bits(16'b1101_0000, 8, 1'b0);
        idle(6, 1'b0);
        @(negedge clk);
        check_val("done_before_reset", bus.done, 1);
        #1 reset_n = 1'b0;
        #1;
        check_val("done_in_reset", bus.done, 0);
        check_val("shift_in_reset", bus.shift_ena, 0);
        check_val("count_in_reset", bus.counting, 0);
        check_val("delay_in_reset", bus.delay_val, 0);
        check_val("remaining_in_reset", bus.remaining, 0);
        #1 reset_n = 1'b1;
        model_reset();
        model_step(bus.x, bus.abort, bus.ack);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            run_cycle(bit'($urandom_range(0, 1)),
                      bit'($urandom_range(0, 59) == 0),
                      bit'($urandom_range(0, 3) == 0));
        end
        @(negedge clk);
        check_outputs();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/timer_seq_fsm.md
TIMER_SEQ_FSM -- requirements
Module: timer_seq_fsm

Interface
REQ-001 Parameter PAT_LEN, default 4: start-pattern length in bits, minimum 2.
REQ-002 Parameter PATTERN, default 4'b1101: start pattern, PAT_LEN bits, MSB received first.
REQ-003 Parameter DELAY_W, default 4: delay field width in bits, minimum 1.
REQ-004 Parameter TICK, default 1000: clocks per delay unit, minimum 1.
REQ-005 clk  input  1  single clock; all state changes on the rising edge.
REQ-006 reset_n  input  1  asynchronous, active-low reset.
REQ-007 x  input  1  serial data: pattern bits, then delay bits MSB first.
REQ-008 abort  input  1  cancels any sequence in progress.
REQ-009 ack  input  1  user acknowledge of done.
REQ-010 shift_ena  output  1  high while the delay field is shifted in.
REQ-011 counting  output  1  high while the timer runs.
REQ-012 done  output  1  high while the block waits for ack.
REQ-013 delay_val  output  DELAY_W  captured delay field.
REQ-014 remaining  output  DELAY_W  delay units left; valid while counting, 0 otherwise.

Function
REQ-015 The FSM SHALL have four states: SEARCH, SHIFT, COUNT and WAIT.
REQ-016 Outputs SHALL be Moore: shift_ena=SHIFT, counting=COUNT, done=WAIT.
REQ-017 In SEARCH, a PAT_LEN-bit history SHALL shift in x every cycle.
REQ-018 A match SHALL be declared when {history[PAT_LEN-2:0], x}==PATTERN and at least PAT_LEN-1 bits have been collected since entering SEARCH.
REQ-019 Matches SHALL be overlapping; a non-matching bit SHALL NOT discard earlier history.
REQ-020 A match SHALL move the FSM to SHIFT on the same edge, so shift_ena is high in the cycle after the last pattern bit.
REQ-021 SHIFT SHALL last exactly DELAY_W cycles, shifting x into delay_val MSB first.
REQ-022 On the edge that ends SHIFT, the tick counter SHALL load TICK-1 and remaining SHALL load the final delay value.
REQ-023 In COUNT, the tick counter SHALL decrement each cycle.
REQ-024 When the tick counter is 0 and remaining>0, remaining SHALL decrement and the tick counter SHALL reload TICK-1.
REQ-025 When the tick counter is 0 and remaining==0, the FSM SHALL enter WAIT.
REQ-026 COUNT SHALL therefore last exactly (delay_val+1)*TICK cycles.
REQ-027 In WAIT, ack=1 SHALL move the FSM to SEARCH on the next edge and clear the history and fill count.
REQ-028 ack outside WAIT SHALL be ignored.
REQ-029 An ack held high when WAIT is entered SHALL give exactly one cycle of done.
REQ-030 abort=1 in SHIFT, COUNT or WAIT SHALL force SEARCH on the next edge, clear the history, and zero remaining; delay_val SHALL keep its last value.
REQ-031 abort=1 in SEARCH SHALL clear the history.
REQ-032 abort SHALL take priority over ack, a pattern match and counter expiry.
REQ-033 Counter widths SHALL be $clog2(TICK) bits (at least 1) and DELAY_W bits; no counter SHALL wrap.

Reset
REQ-034 When reset_n=0, the block SHALL asynchronously enter SEARCH and clear the history, fill count, delay_val, tick counter and remaining.
REQ-035 During reset, shift_ena, counting and done SHALL be 0, including when reset is asserted in the middle of a sequence.
REQ-036 After reset_n rises, the block SHALL start searching on the first clock edge.

Structure
REQ-037 Package timer_seq_pkg SHALL hold the state enum and the TICK_W/DELAY_W width helper functions.
REQ-038 Pattern matching SHALL be a sub-module, pattern_det (parameters PAT_LEN and PATTERN; inputs clk, reset_n, en, clr, x; output match).
REQ-039 The top level SHALL contain the FSM, the delay shifter and the counters.

Verification (PAT_LEN=4, PATTERN=1101, DELAY_W=4, TICK=4)
REQ-040 Stimulus x=1,1,0,1 then 0,1,0,1 SHALL give: shift_ena for 4 cycles; delay_val=5; counting for 24 cycles with remaining 5 down to 0; done held until ack; then SEARCH.
REQ-041 Overlap: x=1,1,1,0,1 then delay 0000 SHALL be detected; counting SHALL last exactly 4 cycles.
REQ-042 Delay 1111 SHALL give counting for 64 cycles, with remaining never wrapping below 0.
REQ-043 abort in the 10th COUNT cycle SHALL drop counting on the next edge, with remaining=0 and the FSM in SEARCH; a fresh 1101 pattern SHALL then restart the sequence.
REQ-044 reset_n pulsed low between clock edges during WAIT SHALL drop done immediately and bring all outputs to 0.
REQ-045 ack held high through a whole sequence SHALL give exactly one done cycle; ack pulses during COUNT SHALL have no effect.
